// File: rtl/sgdmac_pkg.sv
// ---------------------------------------------------------------------------
// sgdmac_pkg
// Shared definitions for the SG DMA read-address arbiter slice.
//   - AXI burst-type encodings (FIXED / INCR / WRAP)
//   - AR field widths (ARLEN_W, ARSIZE_W, ARBURST_W)
//   - ar_req_t: one unpacked AR request (address + burst attributes).
//     The address field is AR_ADDR_W wide. Arbiter instances with a narrower
//     ADDR_W zero-extend into it.
// ---------------------------------------------------------------------------
package sgdmac_pkg;

    localparam int ARLEN_W   = 4;
    localparam int ARSIZE_W  = 3;
    localparam int ARBURST_W = 2;
    localparam int AR_ADDR_W = 32;

    localparam logic [ARBURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [ARBURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [ARBURST_W-1:0] BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [AR_ADDR_W-1:0] addr;
        logic [ARLEN_W-1:0]   len;
        logic [ARSIZE_W-1:0]  size;
        logic [ARBURST_W-1:0] burst;
    } ar_req_t;

endpackage

// File: rtl/sgdmac_ar_arbiter_mc_if.sv
// ---------------------------------------------------------------------------
// sgdmac_ar_arbiter_mc_if
// AXI AR/R master-side bundle between the arbiter and the memory port.
//   master modport (arbiter): drives m_ar*, m_arvalid_o, m_rready_o;
//                             samples m_arready_i, m_rid_i, m_rvalid_i,
//                             m_rlast_i.
//   slave modport (memory)  : the reverse.
// ID_W / ADDR_W must match the arbiter instance's parameters.
// ---------------------------------------------------------------------------
interface sgdmac_ar_arbiter_mc_if
    import sgdmac_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
);
    logic [ID_W-1:0]      m_arid_o;
    logic [ADDR_W-1:0]    m_araddr_o;
    logic [ARLEN_W-1:0]   m_arlen_o;
    logic [ARSIZE_W-1:0]  m_arsize_o;
    logic [ARBURST_W-1:0] m_arburst_o;
    logic                 m_arvalid_o;
    logic                 m_arready_i;
    logic [ID_W-1:0]      m_rid_i;
    logic                 m_rvalid_i;
    logic                 m_rlast_i;
    logic                 m_rready_o;

    modport master (
        output m_arid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o,
        output m_arvalid_o, m_rready_o,
        input  m_arready_i, m_rid_i, m_rvalid_i, m_rlast_i
    );

    modport slave (
        input  m_arid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o,
        input  m_arvalid_o, m_rready_o,
        output m_arready_i, m_rid_i, m_rvalid_i, m_rlast_i
    );
endinterface

// File: rtl/sgdmac_rr_picker.sv
// ---------------------------------------------------------------------------
// sgdmac_rr_picker
// Round-robin picker over N requesters.
//   clk, rst  : clock, synchronous active-high reset
//   req_i     : request vector
//   update_i  : commit the current pick (pointer moves to idx_o)
//   gnt_o     : one-hot pick (all zero when no request)
//   idx_o     : index of the pick
// The pointer holds the last granted index; the search starts at ptr+1,
// so after reset (ptr = N-1) requester 0 has first priority.
// ---------------------------------------------------------------------------
module sgdmac_rr_picker #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             update_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDX_W'(N - 1);
        end else if (update_i) begin
            ptr_q <= idx_o;
        end
    end
endmodule

// File: rtl/sgdmac_ar_arbiter_mc.sv
// ---------------------------------------------------------------------------
// sgdmac_ar_arbiter_mc
// N-channel AXI read-address arbiter with RID-based R-channel routing.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   src_prio_i      per-channel priority (only with SGDMAC_AR_PRIO_EN)
//   src_arvalid_i   per-channel AR request
//   src_arready_o   per-channel AR accept (one-hot, same cycle as request)
//   src_araddr_i    packed addresses, channel i at [i*ADDR_W +: ADDR_W]
//   src_arlen_i     packed burst lengths (4 b each)
//   src_arsize_i    packed burst sizes (3 b each)
//   src_arburst_i   packed burst types (2 b each)
//   src_rvalid_o    R valid steered to the channel named by RID
//   src_rready_i    per-channel R ready
//   idle_o          no AR pending and no burst outstanding
//   rid_err_o       sticky: an R beat arrived with an out-of-range RID
//   m_if            master side of the AXI AR/R port (interface)
//
// Optional feature macro: SGDMAC_AR_PRIO_EN. When defined, channels with
// their prio bit set win round-robin among themselves whenever any of them
// is eligible.
//
// The AR output is a single register slot. A new grant happens in the same
// cycle the slot is (or becomes) free, so an always-ready master sees one
// AR per cycle. Each channel may have at most MAX_OUTS bursts in flight;
// the count drops on the RLAST handshake of that channel's RID.
// ---------------------------------------------------------------------------
module sgdmac_ar_arbiter_mc
    import sgdmac_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int MAX_OUTS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef SGDMAC_AR_PRIO_EN
    input  logic [N_CH-1:0]           src_prio_i,
`endif
    input  logic [N_CH-1:0]           src_arvalid_i,
    output logic [N_CH-1:0]           src_arready_o,
    input  logic [N_CH*ADDR_W-1:0]    src_araddr_i,
    input  logic [N_CH*ARLEN_W-1:0]   src_arlen_i,
    input  logic [N_CH*ARSIZE_W-1:0]  src_arsize_i,
    input  logic [N_CH*ARBURST_W-1:0] src_arburst_i,
    output logic [N_CH-1:0]           src_rvalid_o,
    input  logic [N_CH-1:0]           src_rready_i,
    output logic                      idle_o,
    output logic                      rid_err_o,
    sgdmac_ar_arbiter_mc_if.master    m_if
);
    localparam int IDX_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(MAX_OUTS + 1);
    localparam logic [ID_W:0]    RID_LIMIT = (ID_W + 1)'(N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTS);

    generate
        if (N_CH < 2 || N_CH > (1 << ID_W)) begin : g_bad_nch
            $error("sgdmac_ar_arbiter_mc: N_CH must be in [2, 2**ID_W]");
        end
        if (MAX_OUTS < 1) begin : g_bad_outs
            $error("sgdmac_ar_arbiter_mc: MAX_OUTS must be at least 1");
        end
        if (ADDR_W > AR_ADDR_W) begin : g_bad_addr
            $error("sgdmac_ar_arbiter_mc: ADDR_W exceeds sgdmac_pkg::AR_ADDR_W");
        end
    endgenerate

    ar_req_t           req_s [N_CH];
    logic [N_CH-1:0]   elig;
    logic [N_CH-1:0]   pick_req;
    logic [N_CH-1:0]   gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              slot_free;
    logic              grant_en;

    ar_req_t           slot_q, slot_d;
    logic [ID_W-1:0]   arid_q, arid_d;
    logic              arvalid_q, arvalid_d;

    logic [CNT_W-1:0]  outs_q [N_CH];
    logic [CNT_W-1:0]  outs_d [N_CH];

    logic              rid_ok;
    logic [N_CH-1:0]   rsel;
    logic              rready;
    logic              r_hs;
    logic [N_CH-1:0]   r_dec;
    logic              rid_err_q, rid_err_d;

    // Unpack the flat source buses and work out who may be granted.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            req_s[i].addr  = AR_ADDR_W'(src_araddr_i[i*ADDR_W +: ADDR_W]);
            req_s[i].len   = src_arlen_i[i*ARLEN_W +: ARLEN_W];
            req_s[i].size  = src_arsize_i[i*ARSIZE_W +: ARSIZE_W];
            req_s[i].burst = src_arburst_i[i*ARBURST_W +: ARBURST_W];
            elig[i]        = src_arvalid_i[i] & (outs_q[i] < CNT_MAX);
        end
    end

`ifdef SGDMAC_AR_PRIO_EN
    logic [N_CH-1:0] prio_elig;
    assign prio_elig = elig & src_prio_i;
    assign pick_req  = (|prio_elig) ? prio_elig : elig;
`else
    assign pick_req  = elig;
`endif

    // Slot accepts a new request when empty or draining this cycle.
    assign slot_free = !arvalid_q | m_if.m_arready_i;
    assign grant_en  = slot_free & (|pick_req);

    sgdmac_rr_picker #(.N(N_CH)) u_picker (
        .clk      (clk),
        .rst      (rst),
        .req_i    (pick_req),
        .update_i (grant_en),
        .gnt_o    (gnt),
        .idx_o    (gnt_idx)
    );

    assign src_arready_o = grant_en ? gnt : '0;

    always_comb begin
        slot_d    = slot_q;
        arid_d    = arid_q;
        arvalid_d = arvalid_q;
        if (slot_free) begin
            arvalid_d = grant_en;
            if (grant_en) begin
                slot_d = req_s[gnt_idx];
                arid_d = ID_W'(gnt_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            slot_q    <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            slot_q    <= slot_d;
        end
    end

    assign m_if.m_arvalid_o = arvalid_q;
    assign m_if.m_arid_o    = arid_q;
    assign m_if.m_araddr_o  = slot_q.addr[ADDR_W-1:0];
    assign m_if.m_arlen_o   = slot_q.len;
    assign m_if.m_arsize_o  = slot_q.size;
    assign m_if.m_arburst_o = slot_q.burst;

    // R routing. An out-of-range RID has no owner, so the beat is drained
    // (rready forced high) and flagged instead of stalling the bus.
    always_comb begin
        rid_ok       = {1'b0, m_if.m_rid_i} < RID_LIMIT;
        src_rvalid_o = '0;
        rsel         = '0;
        rready       = !rid_ok;
        for (int i = 0; i < N_CH; i++) begin
            rsel[i] = rid_ok && (m_if.m_rid_i == ID_W'(i));
            if (rsel[i]) begin
                src_rvalid_o[i] = m_if.m_rvalid_i;
                rready          = src_rready_i[i];
            end
        end
    end

    assign m_if.m_rready_o = rready;
    assign r_hs            = m_if.m_rvalid_i & rready;
    assign r_dec           = (r_hs & m_if.m_rlast_i) ? rsel : '0;
    assign rid_err_d       = rid_err_q | (r_hs & !rid_ok);

    // Outstanding counters. Grant and RLAST on the same channel cancel out;
    // a decrement at zero (stale beat after reset) is ignored.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            outs_d[i] = outs_q[i];
            if (src_arready_o[i] && !r_dec[i]) begin
                outs_d[i] = outs_q[i] + CNT_W'(1);
            end else if (!src_arready_o[i] && r_dec[i] && outs_q[i] != '0) begin
                outs_d[i] = outs_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rid_err_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                outs_q[i] <= '0;
            end
        end else begin
            rid_err_q <= rid_err_d;
            for (int i = 0; i < N_CH; i++) begin
                outs_q[i] <= outs_d[i];
            end
        end
    end

    assign rid_err_o = rid_err_q;

    always_comb begin
        idle_o = !arvalid_q;
        for (int i = 0; i < N_CH; i++) begin
            if (outs_q[i] != '0) begin
                idle_o = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sgdmac_ar_arbiter_mc.sv
module tb_sgdmac_ar_arbiter_mc;
    import sgdmac_pkg::*;

    localparam int N  = 4;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_arvalid;
    logic [N-1:0]    src_arready;
    logic [N*AW-1:0] src_araddr;
    logic [N*4-1:0]  src_arlen;
    logic [N*3-1:0]  src_arsize;
    logic [N*2-1:0]  src_arburst;
    logic [N-1:0]    src_rvalid;
    logic [N-1:0]    src_rready;
    logic            idle;
    logic            rid_err;

    int n_assert = 0;
    int n_fail   = 0;

    sgdmac_ar_arbiter_mc_if #(.ID_W(IW), .ADDR_W(AW)) bus ();

    sgdmac_ar_arbiter_mc #(.N_CH(N), .ID_W(IW), .ADDR_W(AW), .MAX_OUTS(MO)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef SGDMAC_AR_PRIO_EN
        .src_prio_i    ('0),
`endif
        .src_arvalid_i (src_arvalid),
        .src_arready_o (src_arready),
        .src_araddr_i  (src_araddr),
        .src_arlen_i   (src_arlen),
        .src_arsize_i  (src_arsize),
        .src_arburst_i (src_arburst),
        .src_rvalid_o  (src_rvalid),
        .src_rready_i  (src_rready),
        .idle_o        (idle),
        .rid_err_o     (rid_err),
        .m_if          (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (abstract, int-based) ----------------
    int          mo_outs [N];
    int          mo_ptr;
    bit          mo_vld;
    logic [3:0]  mo_id;
    logic [31:0] mo_addr;
    logic [3:0]  mo_len;
    logic [2:0]  mo_size;
    logic [1:0]  mo_burst;
    bit          mo_rerr;
    int          e_g;
    bit          e_free;
    logic [N-1:0] e_arready;
    logic [N-1:0] e_rvalid;
    logic         e_rready;
    logic         e_idle;

    task automatic model_reset();
        for (int c = 0; c < N; c++) mo_outs[c] = 0;
        mo_ptr = N - 1; mo_vld = 0; mo_id = 0; mo_addr = 0;
        mo_len = 0; mo_size = 0; mo_burst = 0; mo_rerr = 0;
    endtask

    task automatic model_comb();
        int rid;
        int tot;
        e_free = !mo_vld || bus.m_arready_i;
        e_g = -1;
        if (e_free) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mo_ptr + k) % N;
                if (e_g < 0 && src_arvalid[c] && mo_outs[c] < MO) e_g = c;
            end
        end
        e_arready = (e_g >= 0) ? N'(1 << e_g) : '0;
        rid = int'(bus.m_rid_i);
        if (rid < N) begin
            e_rvalid = bus.m_rvalid_i ? N'(1 << rid) : '0;
            e_rready = src_rready[rid];
        end else begin
            e_rvalid = '0;
            e_rready = 1'b1;
        end
        tot = 0;
        for (int c = 0; c < N; c++) tot += mo_outs[c];
        e_idle = !mo_vld && (tot == 0);
    endtask

    task automatic model_next();
        int rid;
        int dec;
        if (rst) begin
            model_reset();
            return;
        end
        rid = int'(bus.m_rid_i);
        dec = -1;
        if (bus.m_rvalid_i && e_rready) begin
            if (rid < N) begin
                if (bus.m_rlast_i) dec = rid;
            end else begin
                mo_rerr = 1;
            end
        end
        for (int c = 0; c < N; c++) begin
            if (c == e_g && c != dec) mo_outs[c]++;
            else if (c != e_g && c == dec && mo_outs[c] > 0) mo_outs[c]--;
        end
        if (e_free) begin
            if (e_g >= 0) begin
                mo_vld   = 1;
                mo_ptr   = e_g;
                mo_id    = 4'(e_g);
                mo_addr  = src_araddr[e_g*AW +: AW];
                mo_len   = src_arlen[e_g*4 +: 4];
                mo_size  = src_arsize[e_g*3 +: 3];
                mo_burst = src_arburst[e_g*2 +: 2];
            end else begin
                mo_vld = 0;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src_arvalid = '0; src_araddr = '0; src_arlen = '0;
        src_arsize = '0; src_arburst = '0; src_rready = '0;
        bus.m_arready_i = 1'b0; bus.m_rid_i = '0;
        bus.m_rvalid_i = 1'b0; bus.m_rlast_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        #1;
        n_assert++;
        if (bus.m_arvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_arvalid got=%b want=0", bus.m_arvalid_o);
        end
        n_assert++;
        if (bus.m_araddr_o !== 32'h0 || bus.m_arid_o !== 4'h0 || bus.m_arlen_o !== 4'h0) begin
            n_fail++; $display("FAIL reset_payload addr=%h id=%h len=%h want=0",
                               bus.m_araddr_o, bus.m_arid_o, bus.m_arlen_o);
        end
        n_assert++;
        if (idle !== 1'b1 || rid_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags idle=%b rid_err=%b want 1/0", idle, rid_err);
        end
        n_assert++;
        if (src_arready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_arready got=%b want=0000", src_arready);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.m_arready_i = 1'b1;
        src_arvalid = 4'b0100;
        src_araddr[2*AW +: AW] = 32'h0000_1000;
        src_arlen[2*4 +: 4] = 4'd3;
        src_arsize[2*3 +: 3] = 3'd2;
        src_arburst[2*2 +: 2] = BURST_INCR;
        #1;
        n_assert++;
        if (src_arready !== 4'b0100 || bus.m_arvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL single_grant arready=%b arvalid=%b want 0100/0",
                               src_arready, bus.m_arvalid_o);
        end
        tick();
        src_arvalid = '0;
        n_assert++;
        if (bus.m_arvalid_o !== 1'b1 || bus.m_arid_o !== 4'd2 || bus.m_araddr_o !== 32'h1000 ||
            bus.m_arlen_o !== 4'd3 || bus.m_arsize_o !== 3'd2 || bus.m_arburst_o !== BURST_INCR) begin
            n_fail++; $display("FAIL single_ar vld=%b id=%0d addr=%h len=%0d size=%0d burst=%0d want 1/2/1000/3/2/1",
                               bus.m_arvalid_o, bus.m_arid_o, bus.m_araddr_o, bus.m_arlen_o,
                               bus.m_arsize_o, bus.m_arburst_o);
        end
        n_assert++;
        if (idle !== 1'b0) begin
            n_fail++; $display("FAIL single_busy idle=%b want=0", idle);
        end
        tick();
        n_assert++;
        if (bus.m_arvalid_o !== 1'b0 || idle !== 1'b0) begin
            n_fail++; $display("FAIL single_drain arvalid=%b idle=%b want 0/0 (outs[2]=1)",
                               bus.m_arvalid_o, idle);
        end
        bus.m_rid_i = 4'd2; bus.m_rvalid_i = 1'b1; bus.m_rlast_i = 1'b1; src_rready = 4'b0100;
        #1;
        n_assert++;
        if (src_rvalid !== 4'b0100 || bus.m_rready_o !== 1'b1) begin
            n_fail++; $display("FAIL single_rroute rvalid=%b rready=%b want 0100/1",
                               src_rvalid, bus.m_rready_o);
        end
        tick();
        bus.m_rvalid_i = 1'b0;
        #1;
        n_assert++;
        if (idle !== 1'b1) begin
            n_fail++; $display("FAIL single_idle idle=%b want=1", idle);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.m_arready_i = 1'b1;
        src_arvalid = 4'b1111;
        for (int c = 0; c < N; c++) src_araddr[c*AW +: AW] = 32'h100 * (c + 1);
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            n_assert++;
            if (src_arready !== 4'(1 << (cyc % N))) begin
                n_fail++; $display("FAIL rr_order cyc=%0d got=%b want=%b",
                                   cyc, src_arready, 4'(1 << (cyc % N)));
            end
            if (cyc > 0) begin
                n_assert++;
                if (bus.m_arvalid_o !== 1'b1 || bus.m_arid_o !== 4'((cyc - 1) % N) ||
                    bus.m_araddr_o !== 32'h100 * (((cyc - 1) % N) + 1)) begin
                    n_fail++; $display("FAIL rr_stream cyc=%0d vld=%b id=%0d addr=%h want id=%0d",
                                       cyc, bus.m_arvalid_o, bus.m_arid_o, bus.m_araddr_o, (cyc - 1) % N);
                end
            end
            tick();
        end
    endtask

    task automatic test_outs_limit();
        do_reset();
        bus.m_arready_i = 1'b1;
        src_arvalid = 4'b0001;
        for (int k = 0; k < MO; k++) begin
            #1;
            n_assert++;
            if (src_arready !== 4'b0001) begin
                n_fail++; $display("FAIL limit_fill k=%0d got=%b want=0001", k, src_arready);
            end
            tick();
        end
        src_arvalid = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_assert++;
            if (src_arready !== 4'b0010) begin
                n_fail++; $display("FAIL limit_block k=%0d got=%b want=0010", k, src_arready);
            end
            tick();
        end
        src_arvalid = 4'b0001;
        bus.m_rid_i = 4'd0; bus.m_rvalid_i = 1'b1; bus.m_rlast_i = 1'b1; src_rready = 4'b0001;
        #1;
        n_assert++;
        if (src_arready !== 4'b0000 || bus.m_rready_o !== 1'b1) begin
            n_fail++; $display("FAIL limit_full arready=%b rready=%b want 0000/1",
                               src_arready, bus.m_rready_o);
        end
        tick();
        bus.m_rvalid_i = 1'b0;
        #1;
        n_assert++;
        if (src_arready !== 4'b0001) begin
            n_fail++; $display("FAIL limit_release got=%b want=0001", src_arready);
        end
    endtask

    task automatic test_hold();
        do_reset();
        src_arvalid = 4'b0001;
        src_araddr[0 +: AW] = 32'hA0;
        src_arlen[0 +: 4] = 4'd7;
        #1;
        n_assert++;
        if (src_arready !== 4'b0001) begin
            n_fail++; $display("FAIL hold_first got=%b want=0001", src_arready);
        end
        tick();
        src_arvalid = 4'b0011;
        src_araddr[0 +: AW] = 32'hDEAD;
        src_araddr[AW +: AW] = 32'hB0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_assert++;
            if (bus.m_arvalid_o !== 1'b1 || bus.m_araddr_o !== 32'hA0 || bus.m_arid_o !== 4'd0 ||
                bus.m_arlen_o !== 4'd7 || src_arready !== 4'b0000) begin
                n_fail++; $display("FAIL hold_stable k=%0d vld=%b addr=%h id=%0d len=%0d arready=%b want 1/a0/0/7/0000",
                                   k, bus.m_arvalid_o, bus.m_araddr_o, bus.m_arid_o, bus.m_arlen_o, src_arready);
            end
            tick();
        end
        bus.m_arready_i = 1'b1;
        #1;
        n_assert++;
        if (src_arready !== 4'b0010) begin
            n_fail++; $display("FAIL hold_release got=%b want=0010", src_arready);
        end
        tick();
        n_assert++;
        if (bus.m_arid_o !== 4'd1 || bus.m_araddr_o !== 32'hB0) begin
            n_fail++; $display("FAIL hold_next id=%0d addr=%h want 1/b0", bus.m_arid_o, bus.m_araddr_o);
        end
    endtask

    task automatic test_bad_rid();
        do_reset();
        bus.m_rid_i = 4'd7; bus.m_rvalid_i = 1'b1; bus.m_rlast_i = 1'b1; src_rready = 4'b0000;
        #1;
        n_assert++;
        if (bus.m_rready_o !== 1'b1 || src_rvalid !== 4'b0000 || rid_err !== 1'b0) begin
            n_fail++; $display("FAIL badrid_route rready=%b rvalid=%b err=%b want 1/0000/0",
                               bus.m_rready_o, src_rvalid, rid_err);
        end
        tick();
        bus.m_rvalid_i = 1'b0;
        tick();
        tick();
        n_assert++;
        if (rid_err !== 1'b1 || idle !== 1'b1) begin
            n_fail++; $display("FAIL badrid_sticky err=%b idle=%b want 1/1", rid_err, idle);
        end
        do_reset();
        #1;
        n_assert++;
        if (rid_err !== 1'b0) begin
            n_fail++; $display("FAIL badrid_clear err=%b want=0", rid_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.m_arready_i = 1'b1;
        src_arvalid = 4'b0010;
        tick(); tick(); tick();
        n_assert++;
        if (bus.m_arvalid_o !== 1'b1 || bus.m_arid_o !== 4'd1 || idle !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_pre vld=%b id=%0d idle=%b want 1/1/0",
                               bus.m_arvalid_o, bus.m_arid_o, idle);
        end
        src_arvalid = '0;
        bus.m_arready_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_assert++;
        if (bus.m_arvalid_o !== 1'b0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_post vld=%b idle=%b want 0/1", bus.m_arvalid_o, idle);
        end
        src_arvalid = 4'b1111;
        bus.m_arready_i = 1'b1;
        #1;
        n_assert++;
        if (src_arready !== 4'b0001) begin
            n_fail++; $display("FAIL rstmid_first got=%b want=0001", src_arready);
        end
        tick();
        src_arvalid = '0;
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            src_arvalid = N'($urandom_range(0, 15));
            for (int c = 0; c < N; c++) begin
                src_araddr[c*AW +: AW]  = $urandom;
                src_arlen[c*4 +: 4]     = 4'($urandom_range(0, 15));
                src_arsize[c*3 +: 3]    = 3'($urandom_range(0, 7));
                src_arburst[c*2 +: 2]   = 2'($urandom_range(0, 2));
            end
            bus.m_arready_i = ($urandom_range(0, 3) != 0);
            bus.m_rvalid_i  = ($urandom_range(0, 1) != 0);
            bus.m_rlast_i   = ($urandom_range(0, 1) != 0);
            bus.m_rid_i     = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(4, 15))
                                                          : 4'($urandom_range(0, 3));
            src_rready      = N'($urandom_range(0, 15));
            #1;
            model_comb();
            n_assert++;
            if (src_arready !== e_arready) begin
                n_fail++; $display("FAIL rand_arready cyc=%0d got=%b want=%b", cyc, src_arready, e_arready);
            end
            n_assert++;
            if (bus.m_arvalid_o !== mo_vld || bus.m_arid_o !== mo_id || bus.m_araddr_o !== mo_addr ||
                bus.m_arlen_o !== mo_len || bus.m_arsize_o !== mo_size || bus.m_arburst_o !== mo_burst) begin
                n_fail++; $display("FAIL rand_ar cyc=%0d got vld=%b id=%0d addr=%h len=%0d want vld=%b id=%0d addr=%h len=%0d",
                                   cyc, bus.m_arvalid_o, bus.m_arid_o, bus.m_araddr_o, bus.m_arlen_o,
                                   mo_vld, mo_id, mo_addr, mo_len);
            end
            n_assert++;
            if (src_rvalid !== e_rvalid || bus.m_rready_o !== e_rready) begin
                n_fail++; $display("FAIL rand_r cyc=%0d rvalid=%b rready=%b want %b/%b",
                                   cyc, src_rvalid, bus.m_rready_o, e_rvalid, e_rready);
            end
            n_assert++;
            if (idle !== e_idle || rid_err !== mo_rerr) begin
                n_fail++; $display("FAIL rand_flags cyc=%0d idle=%b err=%b want %b/%b",
                                   cyc, idle, rid_err, e_idle, mo_rerr);
            end
            model_next();
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_outs_limit();
        test_hold();
        test_bad_rid();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
